// File: rtl/program_select_ctrl.sv
// program_select_ctrl: debounced front-panel buttons launch a program index
// held on program_selector while the CPU is kept in reset.
module program_select_ctrl #(
   parameter int NUM_BTN         = 4,
   parameter int SEL_WIDTH       = 32,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int HOLD_CYCLES     = 4,
   parameter int LEVEL_MODE      = 0
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NUM_BTN-1:0]   btn_in,
   output logic [NUM_BTN-1:0]   btn_clean,
   output logic [SEL_WIDTH-1:0] program_selector,
   output logic                 cpu_reset,
   output logic                 busy
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam int KW = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
   typedef enum logic [1:0] {IDLE, LOAD, RELEASE} state_t;
   state_t               state_q, state_d;
   logic [NUM_BTN-1:0]   s1_q, s1_d, s2_q, s2_d;
   logic [NUM_BTN-1:0]   clean_q, clean_d, clean_dly_q, clean_dly_d, rise;
   logic [CW-1:0]        cnt_q [NUM_BTN];
   logic [CW-1:0]        cnt_d [NUM_BTN];
   logic [SEL_WIDTH-1:0] sel_q, sel_d;
   logic                 cpu_q, cpu_d;
   logic [HW-1:0]        hold_q, hold_d;
   logic [KW-1:0]        chan_q, chan_d, pick;
   always_comb begin
      s1_d        = btn_in;
      s2_d        = s1_q;
      clean_dly_d = clean_q;
      clean_d     = clean_q;
      cnt_d       = cnt_q;
      for (int i = 0; i < NUM_BTN; i++) begin
         if (s2_q[i] == clean_q[i]) cnt_d[i] = '0;
         else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
            clean_d[i] = s2_q[i];
            cnt_d[i]   = '0;
         end else cnt_d[i] = cnt_q[i] + CW'(1);
      end
   end
   assign rise = clean_q & ~clean_dly_q;
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cpu_d   = cpu_q;
      hold_d  = hold_q;
      chan_d  = chan_q;
      pick    = '0;
      // descending scan leaves the lowest risen channel in pick
      for (int i = NUM_BTN - 1; i >= 0; i--) if (rise[i]) pick = KW'(i);
      case (state_q)
         IDLE: if (|rise) begin
            sel_d   = SEL_WIDTH'(pick) + SEL_WIDTH'(1);
            cpu_d   = 1'b1;
            hold_d  = HW'(HOLD_CYCLES - 1);
            chan_d  = pick;
            state_d = LOAD;
         end
         LOAD: if (hold_q != '0) hold_d = hold_q - HW'(1);
         else if (LEVEL_MODE == 0 || !clean_q[chan_q]) begin
            sel_d   = '0;
            cpu_d   = 1'b0;
            state_d = RELEASE;
         end
         RELEASE: if (clean_q == '0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         s1_q        <= '0;
         s2_q        <= '0;
         clean_q     <= '0;
         clean_dly_q <= '0;
         cnt_q       <= '{default: '0};
         sel_q       <= '0;
         cpu_q       <= 1'b0;
         hold_q      <= '0;
         chan_q      <= '0;
      end else begin
         state_q     <= state_d;
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         clean_q     <= clean_d;
         clean_dly_q <= clean_dly_d;
         cnt_q       <= cnt_d;
         sel_q       <= sel_d;
         cpu_q       <= cpu_d;
         hold_q      <= hold_d;
         chan_q      <= chan_d;
      end
   end
   assign btn_clean        = clean_q;
   assign program_selector = sel_q;
   assign cpu_reset        = cpu_q;
   assign busy             = (state_q != IDLE);
endmodule

// File: tb/tb_program_select_ctrl.sv
// tb_program_select_ctrl: directed checks of debounce, launch, hold and
// release timing for edge-held and level-held instances.
module tb_program_select_ctrl;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  b0 = '0, b1 = '0;
   logic [3:0]  clean0, clean1;
   logic [31:0] sel0, sel1;
   logic        cpu0, cpu1, busy0, busy1;
   int          n_checks = 0;
   int          n_fail = 0;
   program_select_ctrl #(.NUM_BTN(4), .SEL_WIDTH(32), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(4), .LEVEL_MODE(0)) dut0 (
      .clock(clock), .reset(reset), .btn_in(b0), .btn_clean(clean0),
      .program_selector(sel0), .cpu_reset(cpu0), .busy(busy0));
   program_select_ctrl #(.NUM_BTN(4), .SEL_WIDTH(32), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(4), .LEVEL_MODE(1)) dut1 (
      .clock(clock), .reset(reset), .btn_in(b1), .btn_clean(clean1),
      .program_selector(sel1), .cpu_reset(cpu1), .busy(busy1));
   always #5 clock = ~clock;
   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   initial begin
      #1;
      chk("rst_sel", sel0, 0);
      chk("rst_cpu", {31'b0, cpu0}, 0);
      chk("rst_busy", {31'b0, busy0}, 0);
      chk("rst_clean", {28'b0, clean0}, 0);
      tick(2);
      reset = 1'b0;
      // long press on channel 2, edge mode
      b0 = 4'b0100;
      tick(6);
      chk("p2_clean_e6", {28'b0, clean0}, 32'h4);
      chk("p2_sel_e6", sel0, 0);
      tick(1);
      chk("p2_sel_e7", sel0, 3);
      chk("p2_cpu_e7", {31'b0, cpu0}, 1);
      chk("p2_busy_e7", {31'b0, busy0}, 1);
      tick(3);
      chk("p2_sel_e10", sel0, 3);
      tick(1);
      chk("p2_sel_e11", sel0, 0);
      chk("p2_cpu_e11", {31'b0, cpu0}, 0);
      chk("p2_busy_e11", {31'b0, busy0}, 1);
      tick(19);
      chk("p2_sel_held", sel0, 0);
      chk("p2_busy_held", {31'b0, busy0}, 1);
      b0 = 4'b0000;
      tick(6);
      chk("p2_clean_fall", {28'b0, clean0}, 0);
      chk("p2_busy_fall", {31'b0, busy0}, 1);
      tick(1);
      chk("p2_busy_idle", {31'b0, busy0}, 0);
      // 3-cycle glitch on channel 0
      b0 = 4'b0001;
      tick(3);
      b0 = 4'b0000;
      for (int i = 0; i < 12; i++) begin
         tick(1);
         chk("glitch_clean", {28'b0, clean0}, 0);
         chk("glitch_sel", sel0, 0);
      end
      // simultaneous rises on channels 1 and 3
      b0 = 4'b1010;
      tick(6);
      chk("sim_clean", {28'b0, clean0}, 32'ha);
      tick(1);
      chk("sim_sel", sel0, 2);
      tick(4);
      chk("sim_sel_end", sel0, 0);
      chk("sim_busy_rel", {31'b0, busy0}, 1);
      b0 = 4'b0000;
      tick(7);
      chk("sim_busy_idle", {31'b0, busy0}, 0);
      for (int i = 0; i < 10; i++) begin
         tick(1);
         chk("sim_no_queue_sel", sel0, 0);
         chk("sim_no_queue_busy", {31'b0, busy0}, 0);
      end
      // re-press during LOAD and RELEASE is ignored
      b0 = 4'b0001;
      tick(7);
      chk("rp_sel", sel0, 1);
      tick(1);
      b0 = 4'b0000;
      tick(2);
      b0 = 4'b0001;
      tick(1);
      chk("rp_sel_e11", sel0, 0);
      chk("rp_clean_e11", {28'b0, clean0}, 1);
      chk("rp_busy_e11", {31'b0, busy0}, 1);
      tick(8);
      chk("rp_sel_rel", sel0, 0);
      chk("rp_busy_rel", {31'b0, busy0}, 1);
      b0 = 4'b0000;
      tick(7);
      chk("rp_busy_idle", {31'b0, busy0}, 0);
      b0 = 4'b0001;
      tick(6);
      chk("rp2_sel_e6", sel0, 0);
      tick(1);
      chk("rp2_sel_e7", sel0, 1);
      tick(4);
      chk("rp2_sel_e11", sel0, 0);
      b0 = 4'b0000;
      tick(7);
      chk("rp2_busy_idle", {31'b0, busy0}, 0);
      // reset two cycles into LOAD with button held
      b0 = 4'b0010;
      tick(7);
      chk("rl_sel", sel0, 2);
      tick(2);
      reset = 1'b1;
      #1;
      chk("rl_sel_rst", sel0, 0);
      chk("rl_cpu_rst", {31'b0, cpu0}, 0);
      chk("rl_busy_rst", {31'b0, busy0}, 0);
      chk("rl_clean_rst", {28'b0, clean0}, 0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      tick(6);
      chk("rl_sel_e6", sel0, 0);
      chk("rl_busy_e6", {31'b0, busy0}, 0);
      tick(1);
      chk("rl_sel_e7", sel0, 2);
      chk("rl_cpu_e7", {31'b0, cpu0}, 1);
      tick(4);
      chk("rl_sel_e11", sel0, 0);
      b0 = 4'b0000;
      tick(7);
      chk("rl_busy_idle", {31'b0, busy0}, 0);
      // level mode: hold extends while the button stays pressed
      b1 = 4'b0001;
      tick(6);
      chk("lv_sel_e6", sel1, 0);
      tick(1);
      chk("lv_sel_e7", sel1, 1);
      chk("lv_cpu_e7", {31'b0, cpu1}, 1);
      tick(13);
      chk("lv_sel_e20", sel1, 1);
      b1 = 4'b0000;
      tick(6);
      chk("lv_clean_fall", {28'b0, clean1}, 0);
      chk("lv_sel_fall", sel1, 1);
      tick(1);
      chk("lv_sel_end", sel1, 0);
      chk("lv_cpu_end", {31'b0, cpu1}, 0);
      chk("lv_busy_rel", {31'b0, busy1}, 1);
      tick(1);
      chk("lv_busy_idle", {31'b0, busy1}, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/program_select_ctrl.md
# program_select_ctrl

Parametrised front-panel program launcher for the Beta labkit top level. It debounces NUM_BTN raw push-buttons and detects rising edges. A press latches a program index onto `program_selector` for a guaranteed HOLD_CYCLES window, during which the regfile copies the switch input and the CPU is held in reset. After the window it forces re-arming on full button release. It replaces the ad-hoc per-button always block and the commented-out debouncers at the labkit top.

## Interface
- NUM_BTN, 4, number of button channels; channel k launches program k+1
- SEL_WIDTH, 32, width of `program_selector`; must be ≥ clog2(NUM_BTN+1)
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a button level change; ≥1
- HOLD_CYCLES, 4, minimum cycles `program_selector` is held non-zero; ≥1
- LEVEL_MODE, 0, 0 = hold exactly HOLD_CYCLES; 1 = hold while the launching button stays pressed, minimum HOLD_CYCLES

Ports:
- clock  in  1  system clock; all flops on the rising edge
- reset  in  1  asynchronous, active-high; clears every flop immediately
- btn_in  in  NUM_BTN  raw asynchronous buttons, active-high
- btn_clean  out  NUM_BTN  debounced button levels
- program_selector  out  SEL_WIDTH  0 = none; k+1 = program for channel k; zero-extended
- cpu_reset  out  1  high exactly while `program_selector` is non-zero
- busy  out  1  high whenever the FSM is not in IDLE

## Operation
- Per channel: 2-flop synchroniser (s1→s2) feeds a debounce counter of width clog2(DEBOUNCE_CYCLES+1).
  - Counter clears on any cycle with s2 == clean.
  - On a mismatch cycle, if the counter == DEBOUNCE_CYCLES-1, then clean ← s2 and the counter clears; otherwise the counter increments.
- Rise detect: rise[k] = clean[k] & ~clean_d[k], where clean_d is a 1-cycle delayed copy.
- FSM, 3 states; all outputs are registered.
  - IDLE: `program_selector`=0, `cpu_reset`=0. If any rise is seen, pick the lowest k with rise[k]=1. Then set `program_selector`←k+1, `cpu_reset`←1, hold counter←HOLD_CYCLES-1, and go to LOAD.
  - LOAD: rises on all channels are ignored.
    - If counter≠0, decrement.
    - If counter==0 and (LEVEL_MODE==0 or clean[k]==0), clear `program_selector` and `cpu_reset`, then go to RELEASE.
    - If counter==0, LEVEL_MODE==1 and clean[k]==1, stay in LOAD.
  - RELEASE: outputs are 0. Go to IDLE on the first cycle where all clean==0. No launch is possible while any button is held.
- Simultaneous rises: lowest index wins; the other channels are not queued.
- A launch channel index k is held in a register for the LEVEL_MODE check.
- Reset mid-LOAD: outputs go to 0 asynchronously and the FSM returns to IDLE. After release, a still-held button produces a fresh rise once debounced and launches again.

## Timing
- Reset values:
  - `program_selector`=0, `cpu_reset`=0, `busy`=0, `btn_clean`=0
  - all counters 0, clean_d=0, state IDLE
- Edge numbering: edge 1 is the first rising clock edge that samples btn_in[k]=1, with the input stable afterwards.
  - s2 is high after edge 2.
  - `btn_clean[k]` is high after edge DEBOUNCE_CYCLES+2.
  - `program_selector` = k+1 and `busy`=1 after edge DEBOUNCE_CYCLES+3.
- LEVEL_MODE=0: `program_selector` stays non-zero for exactly HOLD_CYCLES clock cycles.
- LEVEL_MODE=1: the hold extends while clean[k]=1 and ends 1 cycle after clean[k] falls, provided HOLD_CYCLES has elapsed.
- Release latency: a button fall takes DEBOUNCE_CYCLES+2 edges to clear `btn_clean`. `busy` drops 1 edge after all `btn_clean`=0 in RELEASE.
- Glitch rejection: a mismatch lasting fewer than DEBOUNCE_CYCLES cycles at s2 never changes `btn_clean`.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and HOLD_CYCLES=4.
- Press btn_in[2] and hold for 30 cycles, LEVEL_MODE=0 -> after edge 7 `program_selector`=3 and `cpu_reset`=1; both are 0 after edge 11; `busy` stays 1 until 1 edge after `btn_clean[2]` falls; no second launch.
- 3-cycle pulse on btn_in[0] -> `btn_clean` and `program_selector` stay 0 throughout.
- btn_in[1] and btn_in[3] rise on the same edge -> `program_selector`=2 only; no launch for channel 3 after release.
- LEVEL_MODE=1, hold btn_in[0] for 20 cycles -> `program_selector`=1 from edge 7 until 1 edge after `btn_clean[0]` falls (≥4 cycles).
- Assert reset for 1 cycle, 2 cycles into LOAD, keeping btn_in[1] held -> `program_selector`, `cpu_reset` and `busy` all read 0 immediately. The next launch appears 7 edges after reset deasserts (debounce restarts from clean=0), with `program_selector`=2.
- Press btn_in[0] again during LOAD and RELEASE -> ignored; a clean re-press after full release launches with the nominal 7-edge latency.
